// File: rtl/perf_cntr_arbiter_if.sv
// ---------------------------------------------------------------------------
// perf_cntr_arbiter_if
//   Bundles the per-core MMIO request bus and the shared cycle-counter port
//   that perf_cntr_arbiter sits between.
//
//   Core side : req_i, we_i, addr_i (4b/core), wdata_i (3b/core) in;
//               ack_o, rvalid_o (one-hot), rdata_o (32b) out.
//   Counter   : cntr_addr_o, cntr_wdata_o, cntr_w_en_o out; cntr_rdata_i in.
//
//   Modports:
//     master - everything outside the arbiter (requesters + counter model)
//     slave  - the arbiter itself
// ---------------------------------------------------------------------------
interface perf_cntr_arbiter_if #(
  parameter int N_CORES = 4
);
  logic [N_CORES-1:0]   req_i;
  logic [N_CORES-1:0]   we_i;
  logic [4*N_CORES-1:0] addr_i;
  logic [3*N_CORES-1:0] wdata_i;
  logic [N_CORES-1:0]   ack_o;
  logic [N_CORES-1:0]   rvalid_o;
  logic [31:0]          rdata_o;
  logic [3:0]           cntr_addr_o;
  logic [2:0]           cntr_wdata_o;
  logic                 cntr_w_en_o;
  logic [31:0]          cntr_rdata_i;

  modport master (
    output req_i, we_i, addr_i, wdata_i, cntr_rdata_i,
    input  ack_o, rvalid_o, rdata_o, cntr_addr_o, cntr_wdata_o, cntr_w_en_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, cntr_rdata_i,
    output ack_o, rvalid_o, rdata_o, cntr_addr_o, cntr_wdata_o, cntr_w_en_o
  );
endinterface

// File: rtl/perf_cntr_arbiter.sv
// ---------------------------------------------------------------------------
// perf_cntr_arbiter
//   Round-robin arbiter sharing one cycle-counter unit (64-bit mcycle plus a
//   2-bit control register, one-cycle registered read) among N_CORES cores.
//   One access is granted per cycle; the grant is combinational, and the
//   read word coming back from the counter one cycle later is routed to the
//   core that was granted.
//
//   Ports:
//     clk_i    - system clock
//     rst_ni   - asynchronous active-low reset
//     bus      - perf_cntr_arbiter_if.slave (core request bus + counter port)
//     owner_o  - {owner_vld, owner_id}, only with PERF_ARB_LOCK_EN
//
//   Build option:
//     PERF_ARB_LOCK_EN - a core that writes ctrl=1 (addr 0) becomes owner of
//                        the counter; control writes from other cores are
//                        still acked but never reach the counter until the
//                        owner writes a non-run value. Reads are never blocked.
// ---------------------------------------------------------------------------
module perf_cntr_arbiter #(
  parameter  int N_CORES = 4,
  localparam int IDW     = $clog2(N_CORES)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  perf_cntr_arbiter_if.slave   bus
`ifdef PERF_ARB_LOCK_EN
  ,
  output logic [IDW:0]         owner_o
`endif
);

  logic [IDW-1:0] rr_ptr;
  logic           resp_vld;
  logic [IDW-1:0] resp_id;

  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [3:0]     g_addr;
  logic [2:0]     g_wdata;
  logic           g_we;
  logic           blocked;

  // Grant search: first asserted request at or after rr_ptr, wrapping.
  // Held off while reset is asserted so every output reads 0 in reset.
  // NOTE: every variable gets a default before the loop; without it the
  // tool would infer a latch on the paths where no request matches.
  always_comb begin : grant_search
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < N_CORES; k++) begin
      idx = (int'(rr_ptr) + k) % N_CORES;
      if (rst_ni && !gnt_vld && bus.req_i[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  assign g_addr  = bus.addr_i[int'(gnt_id)*4 +: 4];
  assign g_wdata = bus.wdata_i[int'(gnt_id)*3 +: 3];
  assign g_we    = bus.we_i[gnt_id];

  always_comb begin
    bus.ack_o        = '0;
    bus.ack_o[gnt_id] = gnt_vld;
    bus.cntr_addr_o  = gnt_vld ? g_addr  : 4'd0;
    bus.cntr_wdata_o = gnt_vld ? g_wdata : 3'd0;
    bus.cntr_w_en_o  = gnt_vld && g_we && !blocked;
  end

  // Response side: the counter's read data is already registered, so it is
  // only steered to the core captured at grant time and masked otherwise.
  always_comb begin
    bus.rvalid_o          = '0;
    bus.rvalid_o[resp_id] = resp_vld;
    bus.rdata_o           = resp_vld ? bus.cntr_rdata_i : 32'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      resp_vld <= 1'b0;
      resp_id  <= '0;
    end else begin
      if (gnt_vld) begin
        rr_ptr <= (int'(gnt_id) == N_CORES-1) ? '0 : gnt_id + 1'b1;
      end
      resp_vld <= gnt_vld && !g_we;
      if (gnt_vld && !g_we) begin
        resp_id <= gnt_id;
      end
    end
  end

`ifdef PERF_ARB_LOCK_EN
  logic           owner_vld;
  logic [IDW-1:0] owner_id;
  logic           ctrl_wr;
  logic           is_owner;
  logic           take_own;
  logic           drop_own;

  assign ctrl_wr  = gnt_vld && g_we && (g_addr == 4'd0);
  assign is_owner = owner_vld && (owner_id == gnt_id);
  // ctrl=1 (run) claims the counter; any other ctrl value from the owner
  // hands it back.
  assign take_own = ctrl_wr && (g_wdata[1:0] == 2'd1) && (!owner_vld || is_owner);
  assign drop_own = ctrl_wr && is_owner && (g_wdata[1:0] != 2'd1);
  assign blocked  = ctrl_wr && owner_vld && !is_owner;
  assign owner_o  = {owner_vld, owner_id};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_vld <= 1'b0;
      owner_id  <= '0;
    end else if (take_own) begin
      owner_vld <= 1'b1;
      owner_id  <= gnt_id;
    end else if (drop_own) begin
      owner_vld <= 1'b0;
    end
  end
`else
  assign blocked = 1'b0;
`endif

endmodule

// File: tb/tb_perf_cntr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_perf_cntr_arbiter
//   Self-checking bench for perf_cntr_arbiter (N_CORES = 4). Directed
//   scenarios use hand-derived constants; the random scenario compares every
//   cycle against a transaction-level model (pointer, pending read, owner).
//   Build with +define+PERF_ARB_LOCK_EN to also exercise the lock feature.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_perf_cntr_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  perf_cntr_arbiter_if #(.N_CORES(N)) bus ();

`ifdef PERF_ARB_LOCK_EN
  logic [IDW:0] owner_o;
`endif

  perf_cntr_arbiter #(.N_CORES(N)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
`ifdef PERF_ARB_LOCK_EN
    ,
    .owner_o(owner_o)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference model state (transaction level)
  int m_ptr;
  int m_pend;          // core awaiting read data next cycle, -1 if none
  bit m_own_vld;
  int m_own_id;

  // Expected values for the cycle just driven
  logic [N-1:0]  exp_ack;
  logic [N-1:0]  exp_rvalid;
  logic [31:0]   exp_rdata;
  logic [3:0]    exp_addr;
  logic [2:0]    exp_wdata;
  logic          exp_wen;
  logic [IDW:0]  exp_owner;

  task automatic model_reset();
    m_ptr     = 0;
    m_pend    = -1;
    m_own_vld = 0;
    m_own_id  = 0;
  endtask

  // Drive one cycle at the falling edge, derive expectations from the model,
  // advance the model to its post-rising-edge state, and leave the caller
  // 1 ns after the drive point to compare.
  task automatic drive(input logic [N-1:0] req, input logic [N-1:0] we,
                       input logic [4*N-1:0] addr, input logic [3*N-1:0] wdata);
    int g;
    logic [3:0] a;
    logic [2:0] w;
    @(negedge clk_i);
    bus.req_i        = req;
    bus.we_i         = we;
    bus.addr_i       = addr;
    bus.wdata_i      = wdata;
    bus.cntr_rdata_i = $urandom;

    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;

    exp_rvalid = (m_pend >= 0) ? N'(1 << m_pend) : '0;
    exp_rdata  = (m_pend >= 0) ? bus.cntr_rdata_i : 32'd0;
    exp_owner  = {m_own_vld, IDW'(m_own_id)};
    exp_ack    = '0;
    exp_addr   = '0;
    exp_wdata  = '0;
    exp_wen    = 1'b0;
    m_pend     = -1;
    if (g >= 0) begin
      a         = addr[4*g +: 4];
      w         = wdata[3*g +: 3];
      exp_ack   = N'(1 << g);
      exp_addr  = a;
      exp_wdata = w;
      exp_wen   = we[g];
`ifdef PERF_ARB_LOCK_EN
      if (we[g] && a == 4'd0) begin
        if (m_own_vld && m_own_id != g) exp_wen = 1'b0;
        else if (w[1:0] == 2'd1) begin m_own_vld = 1; m_own_id = g; end
        else if (m_own_vld) m_own_vld = 0;
      end
`endif
      if (!we[g]) m_pend = g;
      m_ptr = (g + 1) % N;
    end
    #1;
  endtask

  task automatic idle();
    drive('0, '0, '0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk_i);
    rst_ni           = 1'b0;
    bus.req_i        = '0;
    bus.we_i         = '0;
    bus.addr_i       = '0;
    bus.wdata_i      = '0;
    bus.cntr_rdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk_i);
    rst_ni           = 1'b0;
    bus.req_i        = '0;
    bus.we_i         = '0;
    bus.addr_i       = '0;
    bus.wdata_i      = '0;
    bus.cntr_rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({bus.ack_o, bus.rvalid_o, bus.rdata_o, bus.cntr_addr_o, bus.cntr_wdata_o,
         bus.cntr_w_en_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got ack=%b rvalid=%b rdata=%h addr=%h wdata=%h wen=%b exp all 0",
               bus.ack_o, bus.rvalid_o, bus.rdata_o, bus.cntr_addr_o, bus.cntr_wdata_o, bus.cntr_w_en_o);
    end
`ifdef PERF_ARB_LOCK_EN
    checks++;
    if (owner_o !== '0) begin
      errors++; $display("FAIL reset_owner got=%b exp=0", owner_o);
    end
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
  endtask

  task automatic test_single_read();
    apply_reset();
    drive(4'b0100, 4'b0000, 16'h0400, '0);
    checks++;
    if (bus.ack_o !== 4'b0100 || bus.cntr_addr_o !== 4'd4 || bus.cntr_w_en_o !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got ack=%b addr=%h wen=%b exp ack=0100 addr=4 wen=0",
               bus.ack_o, bus.cntr_addr_o, bus.cntr_w_en_o);
    end
    idle();
    checks++;
    if (bus.rvalid_o !== 4'b0100 || bus.rdata_o !== bus.cntr_rdata_i) begin
      errors++;
      $display("FAIL single_resp got rvalid=%b rdata=%h exp rvalid=0100 rdata=%h",
               bus.rvalid_o, bus.rdata_o, bus.cntr_rdata_i);
    end
    drive(4'b1111, '0, '0, '0);  // pointer now 3
    checks++;
    if (bus.ack_o !== 4'b1000) begin
      errors++; $display("FAIL single_ptr got ack=%b exp=1000", bus.ack_o);
    end
  endtask

  task automatic test_contention();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, '0, 16'h4444, '0);
      checks++;
      if (bus.ack_o !== N'(1 << (i % N)) || $countones(bus.ack_o) != 1) begin
        errors++; $display("FAIL contention_ack[%0d] got=%b exp=%b", i, bus.ack_o, N'(1 << (i % N)));
      end
      if (i > 0) begin
        checks++;
        if (bus.rvalid_o !== N'(1 << ((i - 1) % N))) begin
          errors++; $display("FAIL contention_rvalid[%0d] got=%b exp=%b", i, bus.rvalid_o,
                             N'(1 << ((i - 1) % N)));
        end
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    drive(4'b0100, '0, '0, '0);
    drive(4'b1001, '0, '0, '0);
    checks++;
    if (bus.ack_o !== 4'b1000) begin
      errors++; $display("FAIL wrap_first got=%b exp=1000", bus.ack_o);
    end
    drive(4'b1001, '0, '0, '0);
    checks++;
    if (bus.ack_o !== 4'b0001) begin
      errors++; $display("FAIL wrap_second got=%b exp=0001", bus.ack_o);
    end
    drive(4'b1111, '0, '0, '0);
    checks++;
    if (bus.ack_o !== 4'b0010) begin
      errors++; $display("FAIL wrap_ptr got=%b exp=0010", bus.ack_o);
    end
  endtask

  task automatic test_write();
    apply_reset();
    drive(4'b0010, 4'b0010, 16'h0000, 12'h008);
    checks++;
    if (bus.ack_o !== 4'b0010 || bus.cntr_w_en_o !== 1'b1 || bus.cntr_wdata_o !== 3'd1 ||
        bus.cntr_addr_o !== 4'd0) begin
      errors++;
      $display("FAIL write_path got ack=%b wen=%b wdata=%h addr=%h exp ack=0010 wen=1 wdata=1 addr=0",
               bus.ack_o, bus.cntr_w_en_o, bus.cntr_wdata_o, bus.cntr_addr_o);
    end
    idle();
    checks++;
    if (bus.rvalid_o !== 4'b0000 || bus.rdata_o !== 32'd0) begin
      errors++; $display("FAIL write_no_rvalid got rvalid=%b rdata=%h exp 0", bus.rvalid_o, bus.rdata_o);
    end
`ifdef PERF_ARB_LOCK_EN
    checks++;
    if (owner_o !== 3'b101) begin
      errors++; $display("FAIL write_owner got=%b exp=101", owner_o);
    end
`endif
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    drive(4'b0001, 4'b0000, 16'h0004, '0);
    checks++;
    if (bus.ack_o !== 4'b0001) begin
      errors++; $display("FAIL midrst_ack got=%b exp=0001", bus.ack_o);
    end
    @(posedge clk_i);
    #2;
    bus.req_i = '0;
    rst_ni    = 1'b0;
    #1;
    checks++;
    if ({bus.ack_o, bus.rvalid_o, bus.rdata_o, bus.cntr_w_en_o} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got ack=%b rvalid=%b rdata=%h wen=%b exp all 0",
               bus.ack_o, bus.rvalid_o, bus.rdata_o, bus.cntr_w_en_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    idle();
    checks++;
    if (bus.rvalid_o !== 4'b0000) begin
      errors++; $display("FAIL midrst_no_rvalid got=%b exp=0000", bus.rvalid_o);
    end
    drive(4'b1111, '0, '0, '0);
    checks++;
    if (bus.ack_o !== 4'b0001) begin
      errors++; $display("FAIL midrst_ptr got=%b exp=0001", bus.ack_o);
    end
  endtask

`ifdef PERF_ARB_LOCK_EN
  task automatic test_lock();
    apply_reset();
    drive(4'b0001, 4'b0001, 16'h0000, 12'h001);
    idle();
    checks++;
    if (owner_o !== 3'b100) begin
      errors++; $display("FAIL lock_take got=%b exp=100", owner_o);
    end
    drive(4'b0100, 4'b0100, 16'h0000, 12'h000);
    checks++;
    if (bus.ack_o !== 4'b0100 || bus.cntr_w_en_o !== 1'b0) begin
      errors++; $display("FAIL lock_block got ack=%b wen=%b exp ack=0100 wen=0",
                         bus.ack_o, bus.cntr_w_en_o);
    end
    idle();
    checks++;
    if (owner_o !== 3'b100) begin
      errors++; $display("FAIL lock_keep got=%b exp=100", owner_o);
    end
    drive(4'b0001, 4'b0001, 16'h0000, 12'h002);
    checks++;
    if (bus.cntr_w_en_o !== 1'b1) begin
      errors++; $display("FAIL lock_owner_wr got wen=%b exp=1", bus.cntr_w_en_o);
    end
    idle();
    checks++;
    if (owner_o !== 3'b000) begin
      errors++; $display("FAIL lock_release got=%b exp=000", owner_o);
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0]   req, we;
    logic [4*N-1:0] addr;
    logic [3*N-1:0] wdata;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      req   = N'($urandom);
      we    = N'($urandom);
      wdata = (3*N)'($urandom);
      for (int k = 0; k < N; k++)
        addr[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
      drive(req, we, addr, wdata);
      checks++;
      if (bus.ack_o !== exp_ack || bus.cntr_addr_o !== exp_addr ||
          bus.cntr_wdata_o !== exp_wdata || bus.cntr_w_en_o !== exp_wen) begin
        errors++;
        $display("FAIL rand_grant[%0d] got ack=%b addr=%h wdata=%h wen=%b exp ack=%b addr=%h wdata=%h wen=%b",
                 i, bus.ack_o, bus.cntr_addr_o, bus.cntr_wdata_o, bus.cntr_w_en_o,
                 exp_ack, exp_addr, exp_wdata, exp_wen);
      end
      checks++;
      if (bus.rvalid_o !== exp_rvalid || bus.rdata_o !== exp_rdata) begin
        errors++;
        $display("FAIL rand_resp[%0d] got rvalid=%b rdata=%h exp rvalid=%b rdata=%h",
                 i, bus.rvalid_o, bus.rdata_o, exp_rvalid, exp_rdata);
      end
`ifdef PERF_ARB_LOCK_EN
      checks++;
      if (owner_o !== exp_owner) begin
        errors++; $display("FAIL rand_owner[%0d] got=%b exp=%b", i, owner_o, exp_owner);
      end
`endif
    end
  endtask

  initial begin
    rst_ni           = 1'b0;
    bus.req_i        = '0;
    bus.we_i         = '0;
    bus.addr_i       = '0;
    bus.wdata_i      = '0;
    bus.cntr_rdata_i = '0;
    model_reset();
    test_reset();
    test_single_read();
    test_contention();
    test_wrap();
    test_write();
    test_reset_mid_read();
`ifdef PERF_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
